// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared types for the mode_counter timer family.
//  Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_FREE     = 2'd0,
        CNT_PERIODIC = 2'd1,
        CNT_ONESHOT  = 2'd2,
        CNT_UPDOWN   = 2'd3
    } cnt_mode_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/cnt_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_prescaler
//  Description : Divide-by-(i_psc+1) of enabled cycles; o_tick marks the last
//                enabled cycle of each period. Used with MODE_COUNTER_PSC_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module cnt_prescaler #(
    parameter int PSC_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  logic [PSC_WIDTH-1:0] i_psc,
    output logic                 o_tick
);

    logic [PSC_WIDTH-1:0] r_psc;
    logic [PSC_WIDTH-1:0] w_psc_nxt;

    assign o_tick = (r_psc == i_psc);

    always_comb begin
        w_psc_nxt = r_psc;
        if (i_clr) begin
            w_psc_nxt = '0;
        end else if (i_en) begin
            w_psc_nxt = o_tick ? '0 : r_psc + 1'b1;
        end
    end

    dffr #(.WIDTH(PSC_WIDTH)) u_psc_q (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_psc_nxt),
        .o_q     (r_psc)
    );

endmodule : cnt_prescaler
`default_nettype wire

// File: rtl/register.sv
`default_nettype none
// ============================================================================
//  Module      : dffr
//  Description : Generic register with asynchronous active-low reset.
//  Revision    : 1.0  initial release
// ============================================================================
module dffr #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q <= RESET_VAL;
        end else begin
            o_q <= i_d;
        end
    end

endmodule : dffr
`default_nettype wire

// File: rtl/mode_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mode_counter
//  Description : Multi-mode timer/counter (free, periodic, one-shot, triangle)
//                with compare match. Optional prescaler: MODE_COUNTER_PSC_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module mode_counter
    import counter_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PSC_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic                  load_i,
    input  cnt_mode_e             mode_i,
    input  logic                  dir_i,
    input  logic [DATA_WIDTH-1:0] reload_i,
    input  logic [DATA_WIDTH-1:0] cmp_i,
    input  logic [PSC_WIDTH-1:0]  psc_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  dir_o,
    output logic                  ovf_o,
    output logic                  cmp_o,
    output logic                  busy_o
);

    localparam logic [DATA_WIDTH-1:0] c_cnt_max = '1;
    localparam logic [DATA_WIDTH-1:0] c_cnt_one = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_cnt, w_cnt_nxt, w_top;
    logic                  r_dir, w_dir_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_ovf, w_ovf_nxt;
    logic                  r_cmp, w_cmp_nxt;
    logic                  w_tick, w_step, w_down, w_term;

`ifdef MODE_COUNTER_PSC_EN
    cnt_prescaler #(.PSC_WIDTH(PSC_WIDTH)) u_prescaler (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_en    (en_i),
        .i_clr   (clr_i | load_i),
        .i_psc   (psc_i),
        .o_tick  (w_tick)
    );
`else
    // Without the prescaler psc_i has no function.
    logic w_unused_psc;
    assign w_unused_psc = ^psc_i;
    assign w_tick       = 1'b1;
`endif

    always_comb begin
        w_top  = (mode_i == CNT_FREE) ? c_cnt_max : reload_i;
        w_down = (mode_i == CNT_UPDOWN) ? r_dir : dir_i;
        w_term = w_down ? (r_cnt == '0) : (r_cnt >= w_top);
        w_step = en_i & w_tick & ~((mode_i == CNT_ONESHOT) & r_done);

        w_cnt_nxt  = r_cnt;
        w_dir_nxt  = (mode_i == CNT_UPDOWN) ? r_dir : dir_i;
        w_done_nxt = r_done;
        w_ovf_nxt  = 1'b0;
        w_cmp_nxt  = 1'b0;

        if (clr_i) begin
            w_cnt_nxt  = '0;
            w_dir_nxt  = 1'b0;
            w_done_nxt = 1'b0;
        end else if (load_i) begin
            w_cnt_nxt  = dat_i;
            w_dir_nxt  = dir_i;
            w_done_nxt = 1'b0;
            w_cmp_nxt  = (dat_i == cmp_i);
        end else if (w_step) begin
            w_ovf_nxt = w_term;
            case (mode_i)
                CNT_FREE, CNT_PERIODIC: begin
                    if (w_term) begin
                        w_cnt_nxt = w_down ? w_top : '0;
                    end else begin
                        w_cnt_nxt = w_down ? r_cnt - 1'b1 : r_cnt + 1'b1;
                    end
                end
                CNT_ONESHOT: begin
                    if (w_term) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_down ? r_cnt - 1'b1 : r_cnt + 1'b1;
                    end
                end
                default: begin
                    // Degenerate triangle: pinned at zero, every step is terminal.
                    if (reload_i == '0) begin
                        w_cnt_nxt = '0;
                        w_ovf_nxt = 1'b1;
                    end else if (w_term) begin
                        w_cnt_nxt = w_down ? c_cnt_one : reload_i - 1'b1;
                        w_dir_nxt = ~r_dir;
                    end else begin
                        w_cnt_nxt = w_down ? r_cnt - 1'b1 : r_cnt + 1'b1;
                    end
                end
            endcase
            w_cmp_nxt = (w_cnt_nxt != r_cnt) & (w_cnt_nxt == cmp_i);
        end
    end

    dffr #(.WIDTH(DATA_WIDTH)) u_cnt_q (
        .i_clk(clk_i), .i_rst_n(rst_n_i), .i_d(w_cnt_nxt), .o_q(r_cnt)
    );
    dffr #(.WIDTH(1)) u_dir_q (
        .i_clk(clk_i), .i_rst_n(rst_n_i), .i_d(w_dir_nxt), .o_q(r_dir)
    );
    dffr #(.WIDTH(1)) u_done_q (
        .i_clk(clk_i), .i_rst_n(rst_n_i), .i_d(w_done_nxt), .o_q(r_done)
    );
    dffr #(.WIDTH(1)) u_ovf_q (
        .i_clk(clk_i), .i_rst_n(rst_n_i), .i_d(w_ovf_nxt), .o_q(r_ovf)
    );
    dffr #(.WIDTH(1)) u_cmp_q (
        .i_clk(clk_i), .i_rst_n(rst_n_i), .i_d(w_cmp_nxt), .o_q(r_cmp)
    );

    assign dat_o  = r_cnt;
    assign dir_o  = r_dir;
    assign ovf_o  = r_ovf;
    assign cmp_o  = r_cmp;
    assign busy_o = en_i & ~((mode_i == CNT_ONESHOT) & r_done);

endmodule : mode_counter
`default_nettype wire
